// File: rtl/collatz_sched.sv
// Round-robin scheduler that accepts one of four requesters and runs its
// Collatz sequence, reporting step count, peak iterate and error status.
module collatz_sched #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] start_val,
  output logic [N-1:0]       gnt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_id,
  output logic [7:0]         steps,
  output logic [WIDTH-1:0]   peak,
  output logic               err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [7:0]       run_steps_q, run_steps_d;
  logic [WIDTH-1:0] run_peak_q, run_peak_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       last_q, last_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [1:0]       done_id_q, done_id_d;
  logic [7:0]       steps_q, steps_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic             err_q, err_d;

  logic             found;
  logic [1:0]       sel;
  logic [1:0]       cand;
  logic [WIDTH+1:0] triple;
  logic [WIDTH-1:0] x_next;
  logic             advance;
  logic             finish;
  logic             finish_err;

  // 3x+1 needs two extra bits so overflow past WIDTH is visible
  assign triple = ({2'b00, x_q} << 1) + {2'b00, x_q} + {{(WIDTH+1){1'b0}}, 1'b1};

  always_comb begin
    found = 1'b0;
    sel   = last_q;
    cand  = last_q;
    for (int k = 1; k <= N; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    run_steps_d = run_steps_q;
    run_peak_d  = run_peak_q;
    id_d        = id_q;
    last_d      = last_q;
    gnt_d       = '0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    steps_d     = steps_q;
    peak_d      = peak_q;
    err_d       = err_q;
    x_next      = x_q;
    advance     = 1'b0;
    finish      = 1'b0;
    finish_err  = 1'b0;

    if (state_q == IDLE) begin
      if (found) begin
        state_d     = RUN;
        x_d         = start_val[int'(sel)*WIDTH +: WIDTH];
        run_peak_d  = start_val[int'(sel)*WIDTH +: WIDTH];
        run_steps_d = 8'd0;
        id_d        = sel;
        last_d      = sel;
        gnt_d       = N'(1) << sel;
      end
    end else begin
      // x==1 is success; a zero start or an exhausted step budget is an error
      if (x_q == WIDTH'(1)) begin
        finish = 1'b1;
      end else if (x_q == '0 || run_steps_q == 8'd255) begin
        finish     = 1'b1;
        finish_err = 1'b1;
      end else if (!x_q[0]) begin
        x_next  = x_q >> 1;
        advance = 1'b1;
      end else if (|triple[WIDTH+1:WIDTH]) begin
        finish     = 1'b1;
        finish_err = 1'b1;
      end else begin
        x_next  = triple[WIDTH-1:0];
        advance = 1'b1;
      end

      if (advance) begin
        x_d         = x_next;
        run_steps_d = run_steps_q + 8'd1;
        if (x_next > run_peak_q) run_peak_d = x_next;
      end

      if (finish) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        done_id_d = id_q;
        steps_d   = run_steps_q;
        peak_d    = run_peak_q;
        err_d     = finish_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      run_steps_q <= '0;
      run_peak_q  <= '0;
      id_q        <= '0;
      last_q      <= 2'd3;
      gnt_q       <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      steps_q     <= '0;
      peak_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      run_steps_q <= run_steps_d;
      run_peak_q  <= run_peak_d;
      id_q        <= id_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      steps_q     <= steps_d;
      peak_q      <= peak_d;
      err_q       <= err_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign steps   = steps_q;
  assign peak    = peak_q;
  assign err     = err_q;

endmodule

// File: doc/collatz_sched.md
COLLATZ_SCHED -- requirements
Module: collatz_sched

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and iterate width in bits.
REQ-002 Parameter N, fixed at 4, SHALL set the number of requesters.
REQ-003 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  4  SHALL carry one request bit per requester.
REQ-006 start_val  input  4*WIDTH  SHALL carry the packed start values; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  4  SHALL be the one-hot, single-cycle acceptance acknowledge.
REQ-008 busy  output  1  SHALL be high while a sequence is running.
REQ-009 done  output  1  SHALL be a single-cycle result-valid pulse.
REQ-010 done_id  output  2  SHALL identify the requester that owns the result.
REQ-011 steps  output  8  SHALL carry the number of Collatz steps taken.
REQ-012 peak  output  WIDTH  SHALL carry the largest iterate seen, including the start value.
REQ-013 err  output  1  SHALL flag a start value of 0, an arithmetic overflow, or the step limit.

Function
REQ-014 The controller SHALL have exactly two states, IDLE and RUN, and SHALL hold an internal iterate x of WIDTH bits.
REQ-015 In IDLE with req nonzero, at the clock edge the controller SHALL select one requester round-robin, capture its start_val into x and peak, clear steps, store the requester id, and enter RUN.
REQ-016 Round-robin search SHALL begin at last_granted+1 (mod 4); last_granted SHALL reset to 3, so requester 0 has first priority.
REQ-017 gnt[id] SHALL be high for exactly the first RUN cycle after acceptance; gnt SHALL be zero in all other cycles.
REQ-018 Each requester SHALL hold req and start_val until it sees gnt and SHALL drop req on the following cycle; req SHALL be ignored outside IDLE.
REQ-019 In RUN with x==1, the controller SHALL go to IDLE and pulse done with err=0.
REQ-020 In RUN with x even and x!=1, x SHALL become x>>1 and steps SHALL increment by 1.
REQ-021 In RUN with x odd and x!=1, 3x+1 SHALL be computed at WIDTH+2 bits.
REQ-022 If that result exceeds 2^WIDTH-1, the controller SHALL go to IDLE and pulse done with err=1, leaving x unchanged.
REQ-023 Otherwise x SHALL become 3x+1 and steps SHALL increment by 1.
REQ-024 peak SHALL update to the new x whenever the new x exceeds peak.
REQ-025 If steps==255 and x!=1 in a RUN cycle, the controller SHALL go to IDLE and pulse done with err=1; steps SHALL saturate at 255.
REQ-026 A start value of 0 SHALL complete on the first RUN cycle with err=1 and steps=0.
REQ-027 Latency: for a start value needing s steps, done SHALL assert s+1 cycles after the gnt cycle.
REQ-028 A new grant MAY occur in the done cycle, giving a minimum spacing of s+2 cycles between gnt pulses.
REQ-029 done_id, steps, peak and err SHALL update only together with the done pulse and SHALL then hold until the next done.
REQ-030 busy SHALL equal (state==RUN).

Reset
REQ-031 Reset SHALL force IDLE and last_granted=3, and SHALL clear gnt, done, busy, done_id, steps, peak, err and x.
REQ-032 Reset during RUN SHALL abort the sequence without producing a done pulse; reset SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Scenario: req=0001, start_val0=6 -> gnt=0001 for 1 cycle; done 9 cycles later with steps=8, peak=16, err=0, done_id=0.
REQ-034 Scenario: start 27 -> steps=111, peak=9232, err=0; start 1 -> done in the cycle after gnt with steps=0, peak=1.
REQ-035 Scenario: req=1111 held, with each requester dropping req after its gnt -> grant order 0,1,2,3; then req=0101 twice -> grant order 0,2.
REQ-036 Scenario: start 0 -> err=1, steps=0; start 65535 -> err=1 from overflow on the first step.
REQ-037 Scenario: reset asserted mid-RUN for start 27 -> no done pulse, all outputs 0; a following request for start 6 completes normally with steps=8.
REQ-038 Scenario: a start value with more than 255 steps, chosen so that no overflow occurs first (find one with a reference model) -> err=1, steps=255.
